uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//   UART receiver; downstream partner of the uart transmitter. Deserialises
//   frames [start, d0..d7, even parity, stop] arriving on rxd at 1/16 of clk16x.
//   Holds the received byte for the CPU, with ready, parity, frame and
//   overrun status. Single clock domain; rxd is asynchronous and synchronised internally.
// PARAMETERS
//   SYNC_STAGES  2   flops in the rxd synchroniser (>=2)
//   OVERSAMPLE   16  clk16x ticks per bit; mid-bit sample at tick OVERSAMPLE/2-1
// PORTS
//   clk16x        in   1  baud rate * 16 clock, sole clock
//   clr           in   1  synchronous reset, active high
//   rxd           in   1  serial input, idle high, asynchronous
//   rdn           in   1  cpu read strobe, active low, sampled on clk16x
//   d_out         out  8  last received byte
//   r_ready       out  1  d_out holds an unread byte
//   parity_error  out  1  parity of the byte in d_out was wrong
//   frame_error   out  1  stop bit of the byte in d_out was 0
//   overrun       out  1  a byte was lost: frame finished while r_ready=1
//   receiving     out  1  FSM not in IDLE
// BEHAVIOUR
// - Reset (clr=1 at posedge): FSM=IDLE; tick=0; bit_idx=0; shift reg=0; d_out=0;
//   r_ready, parity_error, frame_error, overrun, receiving=0; sync flops=1.
//   Reset mid-frame aborts the frame with no status change.
// - rxd_s = rxd after SYNC_STAGES flops; rxd_d = rxd_s delayed 1 cycle.
// - FSM states: IDLE, START, DATA, PARITY, STOP. tick counts 0..OVERSAMPLE-1.
//   IDLE:   rxd_d=1 & rxd_s=0 (falling edge) -> START, tick=0.
//   START:  at tick=7 sample rxd_s: 0 -> DATA, tick=0, bit_idx=0;
//           1 -> IDLE (glitch/false start, no status change).
//   DATA:   at tick=15 sample rxd_s into shift reg LSB-first (d0 first),
//           tick=0; after bit_idx=7 sample -> PARITY.
//   PARITY: at tick=15 sample parity bit, tick=0 -> STOP.
//   STOP:   at tick=15 sample stop bit -> IDLE; same edge: commit frame.
//   So every sample is at mid-bit: 8+16k ticks after the detected edge.
// - Commit (single cycle): d_out<=data; parity_error<=(^data)^parity_bit;
//   frame_error<=~stop_bit; r_ready<=1; overrun<=1 if r_ready was 1 and no
//   read this cycle, else unchanged. New byte always overwrites d_out.
// - Frame error: FSM still returns to IDLE. A new start requires a fresh
//   1->0 edge, so a held-low line (break) yields no further frames.
// - Read: rdn=0 at posedge clears r_ready, overrun, parity_error and
//   frame_error next cycle. rdn held low = repeated clears (harmless).
//   Read while r_ready=0 has no effect.
// - Read and commit on the same edge: commit wins; r_ready stays 1 with the
//   new byte and status; overrun is not set.
// - Latency: r_ready rises SYNC_STAGES+1+8+160 clk16x edges (+-1) after rxd
//   falls at the start bit, i.e. near mid-stop-bit.
// - receiving=1 in START..STOP, 0 in IDLE. Next start edge is accepted
//   immediately after STOP, so back-to-back frames (one stop bit) are
//   received.
// - Data is 8 bits; parity is even over d0..d7 (9-bit XOR of data and parity = 0).
// TESTING
// 1 Frame 0xA5, parity 0, stop 1 -> r_ready=1, d_out=8'hA5, all errors 0,
//   at the latency above; rdn pulse -> r_ready=0.
// 2 Frame 0x01 with parity bit 0 (wrong) -> d_out=8'h01, parity_error=1;
//   read clears it.
// 3 Frame 0x3C, stop bit 0 then line high -> frame_error=1, d_out=8'h3C;
//   next good frame 0x55 -> frame_error=0.
// 4 rxd low pulse of 5 ticks while idle -> no r_ready, FSM back to IDLE,
//   receiving drops within 8 ticks.
// 5 Frames 0x11 then 0x22 back-to-back, no read -> d_out=8'h22, overrun=1;
//   repeat with rdn=0 on the 2nd commit edge -> overrun=0, r_ready=1.
// 6 clr=1 mid-DATA of frame 0xFF -> all outputs 0 next cycle; following
//   frame 0x0F received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, even parity, one stop bit, sampled mid-bit at 1/OVERSAMPLE of clk16x.
// Holds the last byte with ready/parity/frame/overrun status until the CPU reads it via rdn.
module uart_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       clk16x,
  input  logic       clr,
  input  logic       rxd,
  input  logic       rdn,
  output logic [7:0] d_out,
  output logic       r_ready,
  output logic       parity_error,
  output logic       frame_error,
  output logic       overrun,
  output logic       receiving
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxd_d_q;
  logic                   rxd_s;
  logic [TW-1:0]          tick_q, tick_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [7:0]             d_out_q, d_out_d;
  logic                   r_ready_q, r_ready_d;
  logic                   pe_q, pe_d;
  logic                   fe_q, fe_d;
  logic                   ov_q, ov_d;
  logic                   commit;
  logic                   rd;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], rxd};
  assign rxd_s  = sync_q[SYNC_STAGES-1];
  assign rd     = ~rdn;

  always_ff @(posedge clk16x) begin
    if (clr) begin
      state_q   <= IDLE;
      sync_q    <= '1;
      rxd_d_q   <= 1'b1;
      tick_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      d_out_q   <= '0;
      r_ready_q <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      rxd_d_q   <= rxd_s;
      tick_q    <= tick_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      d_out_q   <= d_out_d;
      r_ready_q <= r_ready_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (rxd_d_q && !rxd_s) state_d = START;
      end
      START: begin
        // Half a bit in: a line back high means the edge was a glitch.
        if (tick_q == MID) begin
          tick_d    = '0;
          bit_idx_d = '0;
          state_d   = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_q == LAST) begin
          tick_d    = '0;
          shift_d   = {rxd_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (tick_q == LAST) begin
          tick_d  = '0;
          par_d   = rxd_s;
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick_q == LAST) begin
          tick_d  = '0;
          state_d = IDLE;
          commit  = 1'b1;
        end
      end
      default: begin
        tick_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // A commit takes precedence over a read landing on the same edge.
  always_comb begin
    d_out_d   = d_out_q;
    r_ready_d = r_ready_q;
    pe_d      = pe_q;
    fe_d      = fe_q;
    ov_d      = ov_q;
    if (commit) begin
      d_out_d   = shift_q;
      r_ready_d = 1'b1;
      pe_d      = (^shift_q) ^ par_q;
      fe_d      = ~rxd_s;
      if (r_ready_q && !rd) ov_d = 1'b1;
    end else if (rd) begin
      r_ready_d = 1'b0;
      pe_d      = 1'b0;
      fe_d      = 1'b0;
      ov_d      = 1'b0;
    end
  end

  assign d_out        = d_out_q;
  assign r_ready      = r_ready_q;
  assign parity_error = pe_q;
  assign frame_error  = fe_q;
  assign overrun      = ov_q;
  assign receiving    = (state_q != IDLE);

endmodule
